// File: rtl/fpga_rst_pkg.sv
// fpga_rst_pkg: shared types and constants for the FPGA reset sequencer.
// Build option: FPGA_RST_DEBOUNCE_EN (consumed by fpga_rst_debounce).
package fpga_rst_pkg;

  // Sequencer states: both resets held, hold window, slow clock released, running
  typedef enum logic [1:0] {
    RST_ST_WAIT    = 2'd0,
    RST_ST_HOLD    = 2'd1,
    RST_ST_CLK_REL = 2'd2,
    RST_ST_RUN     = 2'd3
  } rst_seq_state_e;

  // Encoding of the last reset cause reported on rst_cause_o
  localparam logic [1:0] RST_CAUSE_POR  = 2'b00;
  localparam logic [1:0] RST_CAUSE_PAD  = 2'b01;
  localparam logic [1:0] RST_CAUSE_LOCK = 2'b10;

  // Larger of two elaboration-time integers, used to size the shared counter
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/fpga_rst_debounce.sv
// fpga_rst_debounce: synchronizer plus optional debounce filter for the
// board reset button. With FPGA_RST_DEBOUNCE_EN defined the synchronized level
// must differ from the filtered level for DEBOUNCE_CYCLES consecutive cycles
// before the filtered level follows it; otherwise the synchronized level is
// passed straight through and no counter is built.
module fpga_rst_debounce #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic pad_rstn_i,
  output logic pad_db_o
);

  // Reject illegal parameterisations at elaboration
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("fpga_rst_debounce: SYNC_STAGES must be >= 2");
  end
  if (DEBOUNCE_CYCLES < 1) begin : g_bad_db
    $error("fpga_rst_debounce: DEBOUNCE_CYCLES must be >= 1");
  end

  logic [SYNC_STAGES-1:0] pad_sync_q;
  logic                   pad_sync_s;

  // Metastability chain; resets to 0 so the pad reads as "reset asserted"
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pad_sync_q <= '0;
    end else begin
      pad_sync_q <= {pad_sync_q[SYNC_STAGES-2:0], pad_rstn_i};
    end
  end

  assign pad_sync_s = pad_sync_q[SYNC_STAGES-1];

`ifdef FPGA_RST_DEBOUNCE_EN
  localparam int DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            db_q, db_d;

  // Count consecutive cycles of disagreement; adopt the new level on the last one
  always_comb begin
    db_cnt_d = '0;
    db_d     = db_q;
    if (pad_sync_s != db_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        db_d     = pad_sync_s;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + DB_W'(1);
      end
    end else begin
      db_cnt_d = '0;
    end
  end

  // Filter state; the filtered level starts low (reset asserted)
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      db_cnt_q <= '0;
      db_q     <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      db_q     <= db_d;
    end
  end

  assign pad_db_o = db_q;
`else
  assign pad_db_o = pad_sync_s;
`endif

endmodule

// File: rtl/fpga_rst_seq.sv
// fpga_rst_seq: board reset sequencer. Synchronizes the reset button and the
// clock-lock indication, then releases the slow-clock generator reset followed
// by the SoC reset. All outputs are registered. Pad debouncing is controlled by
// FPGA_RST_DEBOUNCE_EN inside fpga_rst_debounce.
module fpga_rst_seq
  import fpga_rst_pkg::*;
#(
  parameter int SYNC_STAGES      = 2,
  parameter int DEBOUNCE_CYCLES  = 50000,
  parameter int CLK_HOLD_CYCLES  = 256,
  parameter int CORE_HOLD_CYCLES = 1024
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       pad_rstn_i,
  input  logic       clk_locked_i,
  output logic       clk_rst_no,
  output logic       core_rst_no,
  output logic       rst_active_o,
  output logic [1:0] rst_cause_o
);

  localparam int CNT_MAX = max_int(CLK_HOLD_CYCLES, CORE_HOLD_CYCLES);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Reject illegal hold lengths at elaboration
  if (CLK_HOLD_CYCLES < 1 || CORE_HOLD_CYCLES < 1) begin : g_bad_hold
    $error("fpga_rst_seq: hold cycle counts must be >= 1");
  end

  logic                   pad_db_s;
  logic [SYNC_STAGES-1:0] lock_sync_q;
  logic                   lock_s;
  logic                   rel_ok_s;

  rst_seq_state_e         state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc_s;
  logic                   clk_rst_q, clk_rst_d;
  logic                   core_rst_q, core_rst_d;
  logic                   active_q, active_d;
  logic [1:0]             cause_q, cause_d;

  fpga_rst_debounce #(
    .SYNC_STAGES     (SYNC_STAGES),
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
  ) u_pad_db (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .pad_rstn_i (pad_rstn_i),
    .pad_db_o   (pad_db_s)
  );

  // Lock synchronizer; not filtered so a lock loss aborts as fast as possible
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lock_sync_q <= '0;
    end else begin
      lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], clk_locked_i};
    end
  end

  assign lock_s   = lock_sync_q[SYNC_STAGES-1];
  assign rel_ok_s = pad_db_s & lock_s;

  // Sequencer next state, saturating counter, cause capture and output decode
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    cause_d   = cause_q;
    cnt_inc_s = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);

    case (state_q)
      RST_ST_WAIT: begin
        cnt_d = '0;
        if (rel_ok_s) begin
          state_d = RST_ST_HOLD;
        end else begin
          state_d = RST_ST_WAIT;
        end
      end
      RST_ST_HOLD: begin
        if (!rel_ok_s) begin
          state_d = RST_ST_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(CLK_HOLD_CYCLES - 1)) begin
          state_d = RST_ST_CLK_REL;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      RST_ST_CLK_REL: begin
        if (!rel_ok_s) begin
          state_d = RST_ST_WAIT;
          cnt_d   = '0;
        end else if (cnt_q == CNT_W'(CORE_HOLD_CYCLES - 1)) begin
          state_d = RST_ST_RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc_s;
        end
      end
      RST_ST_RUN: begin
        cnt_d = '0;
        if (!rel_ok_s) begin
          state_d = RST_ST_WAIT;
        end else begin
          state_d = RST_ST_RUN;
        end
      end
      default: begin
        state_d = RST_ST_WAIT;
        cnt_d   = '0;
      end
    endcase

    // On WAIT entry a low pad takes precedence over a lock loss
    if ((state_q != RST_ST_WAIT) && (state_d == RST_ST_WAIT)) begin
      cause_d = pad_db_s ? RST_CAUSE_LOCK : RST_CAUSE_PAD;
    end else begin
      cause_d = cause_q;
    end

    // Outputs are decoded from the next state so they switch with the state flop
    clk_rst_d  = (state_d == RST_ST_CLK_REL) || (state_d == RST_ST_RUN);
    core_rst_d = (state_d == RST_ST_RUN);
    active_d   = (state_d != RST_ST_RUN);
  end

  // Sequencer registers; rst_ni forces every output to its asserted value at once
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= RST_ST_WAIT;
      cnt_q      <= '0;
      clk_rst_q  <= 1'b0;
      core_rst_q <= 1'b0;
      active_q   <= 1'b1;
      cause_q    <= RST_CAUSE_POR;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clk_rst_q  <= clk_rst_d;
      core_rst_q <= core_rst_d;
      active_q   <= active_d;
      cause_q    <= cause_d;
    end
  end

  assign clk_rst_no   = clk_rst_q;
  assign core_rst_no  = core_rst_q;
  assign rst_active_o = active_q;
  assign rst_cause_o  = cause_q;

endmodule

// File: tb/tb_fpga_rst_seq.sv
// tb_fpga_rst_seq: directed bench for fpga_rst_seq. Expected latencies follow
// from the parameters below; FPGA_RST_DEBOUNCE_EN selects whether the pad path
// includes the debounce delay.
module tb_fpga_rst_seq;

  localparam int SYNC  = 2;
  localparam int DEB   = 4;
  localparam int CLKH  = 8;
  localparam int COREH = 16;
`ifdef FPGA_RST_DEBOUNCE_EN
  localparam int DB_EFF = DEB;
`else
  localparam int DB_EFF = 0;
`endif
  // Pad edge to FSM reaction (HOLD entry or WAIT entry)
  localparam int PAD_LAT = SYNC + DB_EFF + 1;

  logic       clk = 1'b0;
  logic       rst_ni;
  logic       pad;
  logic       lock;
  logic       clk_rst_no;
  logic       core_rst_no;
  logic       rst_active_o;
  logic [1:0] rst_cause_o;

  int tests_run    = 0;
  int tests_failed = 0;

  fpga_rst_seq #(
    .SYNC_STAGES      (SYNC),
    .DEBOUNCE_CYCLES  (DEB),
    .CLK_HOLD_CYCLES  (CLKH),
    .CORE_HOLD_CYCLES (COREH)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .pad_rstn_i   (pad),
    .clk_locked_i (lock),
    .clk_rst_no   (clk_rst_no),
    .core_rst_no  (core_rst_no),
    .rst_active_o (rst_active_o),
    .rst_cause_o  (rst_cause_o)
  );

  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [1:0] obs, input logic [1:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
    end
  endtask

  initial begin
    rst_ni = 1'b0;
    pad    = 1'b1;
    lock   = 1'b1;

    // Power-on
    step(3);
    chk("por_clk_rst", clk_rst_no, 2'd0);
    chk("por_core_rst", core_rst_no, 2'd0);
    chk("por_active", rst_active_o, 2'd1);
    chk("por_cause", rst_cause_o, 2'b00);
    rst_ni = 1'b1;
    step(PAD_LAT + CLKH - 1);
    chk("por_clk_early", clk_rst_no, 2'd0);
    step(1);
    chk("por_clk_rise", clk_rst_no, 2'd1);
    chk("por_core_held", core_rst_no, 2'd0);
    step(COREH - 1);
    chk("por_core_early", core_rst_no, 2'd0);
    chk("por_active_early", rst_active_o, 2'd1);
    step(1);
    chk("por_core_rise", core_rst_no, 2'd1);
    chk("por_active_fall", rst_active_o, 2'd0);
    chk("por_cause_run", rst_cause_o, 2'b00);

`ifdef FPGA_RST_DEBOUNCE_EN
    // Pad glitch one cycle shorter than the filter: no effect
    pad = 1'b0;
    step(3);
    pad = 1'b1;
    for (int i = 0; i < 12; i++) begin
      step(1);
      chk("glitch_clk", clk_rst_no, 2'd1);
      chk("glitch_core", core_rst_no, 2'd1);
    end
`endif

    // Pad reset held for 10 cycles
    pad = 1'b0;
    step(PAD_LAT - 1);
    chk("pad_pre_clk", clk_rst_no, 2'd1);
    chk("pad_pre_core", core_rst_no, 2'd1);
    step(1);
    chk("pad_clk_fall", clk_rst_no, 2'd0);
    chk("pad_core_fall", core_rst_no, 2'd0);
    chk("pad_active", rst_active_o, 2'd1);
    chk("pad_cause", rst_cause_o, 2'b01);
    step(10 - PAD_LAT);
    pad = 1'b1;
    step(PAD_LAT + CLKH - 1);
    chk("pad_replay_clk_early", clk_rst_no, 2'd0);
    step(1);
    chk("pad_replay_clk_rise", clk_rst_no, 2'd1);
    chk("pad_replay_core_held", core_rst_no, 2'd0);

    // Lock lost for one cycle while in CLK_REL
    step(4);
    lock = 1'b0;
    step(1);
    lock = 1'b1;
    step(1);
    chk("lock_pre_clk", clk_rst_no, 2'd1);
    step(1);
    chk("lock_clk_fall", clk_rst_no, 2'd0);
    chk("lock_core", core_rst_no, 2'd0);
    chk("lock_cause", rst_cause_o, 2'b10);
    step(8);
    chk("lock_replay_clk_early", clk_rst_no, 2'd0);
    step(1);
    chk("lock_replay_clk_rise", clk_rst_no, 2'd1);
    step(COREH - 1);
    chk("lock_replay_core_early", core_rst_no, 2'd0);
    step(1);
    chk("lock_replay_core_rise", core_rst_no, 2'd1);
    chk("lock_replay_active", rst_active_o, 2'd0);
    chk("lock_replay_cause", rst_cause_o, 2'b10);

    // Pad filter output and synced lock fall on the same edge: pad wins
    pad = 1'b0;
    step(DB_EFF);
    lock = 1'b0;
    step(2);
    chk("simul_pre_clk", clk_rst_no, 2'd1);
    chk("simul_pre_cause", rst_cause_o, 2'b10);
    step(1);
    chk("simul_clk", clk_rst_no, 2'd0);
    chk("simul_core", core_rst_no, 2'd0);
    chk("simul_cause", rst_cause_o, 2'b01);

    // Asynchronous reset while in HOLD
    pad  = 1'b1;
    lock = 1'b1;
    step(PAD_LAT + 3);
    chk("hold_clk", clk_rst_no, 2'd0);
    chk("hold_cause", rst_cause_o, 2'b01);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("async_hold_cause", rst_cause_o, 2'b00);
    chk("async_hold_clk", clk_rst_no, 2'd0);
    chk("async_hold_active", rst_active_o, 2'd1);
    step(2);
    rst_ni = 1'b1;

    // Full sequence again, then asynchronous reset from RUN between edges
    step(PAD_LAT + CLKH + COREH);
    chk("rerun_clk", clk_rst_no, 2'd1);
    chk("rerun_core", core_rst_no, 2'd1);
    chk("rerun_active", rst_active_o, 2'd0);
    #3;
    rst_ni = 1'b0;
    #1;
    chk("async_run_clk", clk_rst_no, 2'd0);
    chk("async_run_core", core_rst_no, 2'd0);
    chk("async_run_active", rst_active_o, 2'd1);
    chk("async_run_cause", rst_cause_o, 2'b00);
    step(2);
    rst_ni = 1'b1;
    step(2);
    chk("post_release_clk", clk_rst_no, 2'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/fpga_rst_seq.md
# fpga_rst_seq

Reset sequencer between the raw board reset pad (after its IBUF) and the reset inputs of the FPGA slow-clock generator and the `core_v_mcu` top. It synchronizes and debounces the push-button reset and monitors the clock-ready indication. It releases two resets in a fixed order: first to the slow-clock generator, then to the SoC. Outputs are glitch-free registered resets in the reference-clock domain.

## Interface
- `SYNC_STAGES`, 2: flip-flop stages on each asynchronous input; legal range ≥2.
- `DEBOUNCE_CYCLES`, 50000: consecutive stable cycles needed before the debounced pad level changes; legal range ≥1.
- `CLK_HOLD_CYCLES`, 256: cycles that both resets are held after release conditions are met; legal range ≥1.
- `CORE_HOLD_CYCLES`, 1024: cycles between `clk_rst_no` release and `core_rst_no` release; legal range ≥1.
- `clk_i`  in  1  reference clock (buffered `ref_clk`).
- `rst_ni`  in  1  asynchronous, active-low block reset (configuration-done / constant-high on board).
- `pad_rstn_i`  in  1  raw active-low board reset button, asynchronous to `clk_i`.
- `clk_locked_i`  in  1  clock source ready, asynchronous, active-high.
- `clk_rst_no`  out  1  active-low reset to the slow-clock generator.
- `core_rst_no`  out  1  active-low reset to the SoC `rstn_i`.
- `rst_active_o`  out  1  high whenever `core_rst_no` is low.
- `rst_cause_o`  out  2  cause of the last reset: 00 = power-on (`rst_ni`), 01 = pad, 10 = clock-lock loss; 11 is unused.

## Operation
- `pad_rstn_i` and `clk_locked_i` each pass through `SYNC_STAGES` flops. The synchronizer flops reset to 0.
- Debounce filter:
  - A counter restarts whenever the synchronized pad level differs from the debounced level.
  - The debounced level takes the new value once the difference has persisted for `DEBOUNCE_CYCLES` cycles.
  - The debounced level resets to 0 (reset asserted).
- The synchronized lock signal is not debounced.
- State machine, one-hot or encoded:
  - `WAIT`: `clk_rst_no` = 0 and `core_rst_no` = 0. Go to `HOLD` when debounced pad = 1 and synced lock = 1. Clear the counter.
  - `HOLD`: both resets stay 0. Count to `CLK_HOLD_CYCLES`, then go to `CLK_REL` and clear the counter.
  - `CLK_REL`: `clk_rst_no` = 1 and `core_rst_no` = 0. Count to `CORE_HOLD_CYCLES`, then go to `RUN`.
  - `RUN`: both resets are 1.
- Abort rule: in any state other than `WAIT`, debounced pad = 0 or synced lock = 0 sends the FSM to `WAIT` on the next edge.
- Cause capture: `rst_cause_o` is updated on every `WAIT` entry. If pad and lock fall in the same cycle, pad wins (01).
- A pad assertion shorter than `DEBOUNCE_CYCLES` has no effect.
- Counter width is `$clog2(max(CLK_HOLD_CYCLES, CORE_HOLD_CYCLES)+1)`. The counter saturates and never wraps.
- `rst_ni` low (mid-sequence or not) asynchronously sets all registers to their reset values and the FSM to `WAIT`.

## Timing
- Reset values: `clk_rst_no` = 0, `core_rst_no` = 0, `rst_active_o` = 1, `rst_cause_o` = 00, state = `WAIT`.
- All outputs are flop outputs; there is no combinational path from any input to any output.
- Let T be the first cycle in `HOLD`. Then:
  - `clk_rst_no` rises at T + `CLK_HOLD_CYCLES`.
  - `core_rst_no` and `rst_active_o` change at T + `CLK_HOLD_CYCLES` + `CORE_HOLD_CYCLES`.
- Pad release to T: `SYNC_STAGES` + `DEBOUNCE_CYCLES` + 1 cycles, provided lock is already high.
- Pad assertion to both outputs low: `SYNC_STAGES` + `DEBOUNCE_CYCLES` + 1 cycles.
- Lock loss to both outputs low: `SYNC_STAGES` + 1 cycles.
- Assertion of `rst_ni` is asynchronous. Release of `rst_ni` is acted on from the next `clk_i` edge.

## Configuration
- `FPGA_RST_DEBOUNCE_EN` defined: the debounce filter is built as described above.
- `FPGA_RST_DEBOUNCE_EN` undefined: the debounced level equals the synchronized pad level. `DEBOUNCE_CYCLES` is ignored and no counter is instantiated, so pad latencies shrink by `DEBOUNCE_CYCLES`.

## Structure
- Shared package `fpga_rst_pkg` holds:
  - the state enum `rst_seq_state_e`;
  - the cause encoding constants `RST_CAUSE_POR`, `RST_CAUSE_PAD`, `RST_CAUSE_LOCK`.
- Sub-module `fpga_rst_debounce` contains the synchronizer plus the filter (parameters `SYNC_STAGES`, `DEBOUNCE_CYCLES`). The macro guard lives inside it.
- The lock synchronizer is a plain flop chain in the top level.

## Test plan
Bench parameters: `SYNC_STAGES` = 2, `DEBOUNCE_CYCLES` = 4, `CLK_HOLD_CYCLES` = 8, `CORE_HOLD_CYCLES` = 16, macro defined.
- Power-on: `rst_ni` low for 3 cycles, pad = 1, lock = 1, then release. Expected: `clk_rst_no` rises exactly 8 cycles after `HOLD` entry; `core_rst_no` rises 16 cycles after that; `rst_cause_o` = 00.
- Pad glitch: in `RUN`, drive pad low for 3 cycles. Expected: no output change.
- Pad reset: in `RUN`, drive pad low for 10 cycles. Expected: both outputs go 0 seven cycles after the fall; `rst_cause_o` = 01; full sequence replays after release.
- Lock loss mid-`CLK_REL`: drop lock for 1 cycle. Expected: `clk_rst_no` returns to 0 three cycles later; `rst_cause_o` = 10; sequence restarts once lock is high.
- Simultaneous pad and lock fall (pad debounced in the same cycle as lock is seen). Expected: `rst_cause_o` = 01.
- Async reset during `HOLD`: assert `rst_ni` asynchronously. Expected: outputs at reset values immediately, with no clock edge needed. Rebuild without the macro and confirm pad-to-`WAIT` latency is 3 cycles.
